// File: rtl/gcd_sram_initiator.sv
// gcd_sram_initiator
// Master-side sequencer for the 64-bit GCD SRAM-style register port.
// Host commands become single-cycle SRAM_* strobes:
//   - write bursts stream WR_* words into consecutive words of one region;
//   - read bursts return data through a small credit-managed FIFO to RD_*.
// Optional build macro: GCD_INIT_BYTE_MASK_EN
//   - defined: WR_STRB becomes the byte mask (SRAM_WBEn = ~WR_STRB);
//   - undefined: every write is a full-word write.
`timescale 1ns/1ps

module gcd_sram_initiator #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [3:0]  CMD_REGION,
    input  logic [4:0]  CMD_WORD,
    input  logic [4:0]  CMD_LEN,
    input  logic        CMD_WAIT,
    input  logic        WR_VALID,
    output logic        WR_READY,
    input  logic [63:0] WR_DATA,
    input  logic [7:0]  WR_STRB,
    output logic        RD_VALID,
    input  logic        RD_READY,
    output logic [63:0] RD_DATA,
    input  logic        GCD_DONE,
    output logic        BUSY,
    output logic        SRAM_CEn,
    output logic        SRAM_WEn,
    output logic [7:0]  SRAM_WBEn,
    output logic [31:0] SRAM_ADDR,
    output logic [63:0] SRAM_WDATA,
    input  logic [63:0] SRAM_RDATA
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WAIT, S_READ, S_DRAIN} state_t;
    state_t r_state, w_state_next;

    logic [3:0]    r_region;
    logic [4:0]    r_word;
    logic [5:0]    r_left;          // accesses still to be issued in this burst
    logic          r_rd_strobe;     // read strobe on the port this cycle
    logic          r_rd_ret;        // SRAM_RDATA carries returned data this cycle
    logic [63:0]   r_fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_cmd_fire;
    logic          w_wr_fire;
    logic          w_issue;
    logic          w_credit;
    logic          w_push;
    logic          w_pop;
    logic [1:0]    w_inflight;
    logic [CW:0]   w_occupancy;
    logic [7:0]    w_wbe_write;
    logic [8:0]    w_rd_loc;

`ifdef GCD_INIT_BYTE_MASK_EN
    assign w_wbe_write = ~WR_STRB;
`else
    logic w_unused_strb;
    assign w_unused_strb = ^WR_STRB;
    assign w_wbe_write   = 8'h00;
`endif

    assign w_cmd_fire  = CMD_VALID & CMD_READY;
    assign w_wr_fire   = WR_VALID & WR_READY;
    assign w_inflight  = {1'b0, r_rd_strobe} + {1'b0, r_rd_ret};
    assign w_occupancy = {1'b0, r_count} + (CW+1)'(w_inflight);
    // Every issued read owns a FIFO slot until it is popped, so the FIFO can never overflow.
    assign w_credit    = (w_occupancy < (CW+1)'(FIFO_DEPTH));
    assign w_push      = r_rd_ret;
    assign w_pop       = RD_VALID & RD_READY;
    assign RD_VALID    = (r_count != '0);
    assign RD_DATA     = r_fifo_mem[r_rd_ptr];
    assign BUSY        = (r_state != S_IDLE) | (w_inflight != 2'd0) | (~SRAM_CEn & ~SRAM_WEn);

    // State register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state decision
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (CMD_VALID) begin
                    if (CMD_WRITE)     w_state_next = S_WRITE;
                    else if (CMD_WAIT) w_state_next = S_WAIT;
                    else               w_state_next = S_READ;
                end
            end
            S_WRITE: if (w_wr_fire && r_left == 6'd1) w_state_next = S_IDLE;
            S_WAIT:  if (GCD_DONE) w_state_next = S_READ;
            S_READ:  if (r_left == 6'd0 || (w_issue && r_left == 6'd1)) w_state_next = S_DRAIN;
            S_DRAIN: if (w_inflight == 2'd0) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake readies and read issue; an immediate read may issue in the accepting cycle
    always_comb begin
        CMD_READY = 1'b0;
        WR_READY  = 1'b0;
        w_issue   = 1'b0;
        w_rd_loc  = {r_region, r_word};
        case (r_state)
            S_IDLE: begin
                CMD_READY = 1'b1;
                w_issue   = CMD_VALID & ~CMD_WRITE & ~CMD_WAIT & w_credit;
                w_rd_loc  = {CMD_REGION, CMD_WORD};
            end
            S_WRITE: WR_READY = 1'b1;
            S_READ:  w_issue  = w_credit & (r_left != 6'd0);
            default: ;
        endcase
    end

    // Burst position: region fixed per burst, word wraps 31->0 inside the region
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_region <= 4'd0;
            r_word   <= 5'd0;
            r_left   <= 6'd0;
        end else if (w_cmd_fire) begin
            r_region <= CMD_REGION;
            r_word   <= CMD_WORD + {4'd0, w_issue};
            r_left   <= {1'b0, CMD_LEN} + 6'd1 - {5'd0, w_issue};
        end else if (w_wr_fire || w_issue) begin
            r_word   <= r_word + 5'd1;
            r_left   <= r_left - 6'd1;
        end
    end

    // Registered SRAM port: each strobe lasts one cycle, otherwise the port idles
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            SRAM_CEn    <= 1'b1;
            SRAM_WEn    <= 1'b1;
            SRAM_WBEn   <= 8'hFF;
            SRAM_ADDR   <= 32'd0;
            SRAM_WDATA  <= 64'd0;
            r_rd_strobe <= 1'b0;
        end else begin
            SRAM_CEn    <= 1'b1;
            SRAM_WEn    <= 1'b1;
            SRAM_WBEn   <= 8'hFF;
            r_rd_strobe <= 1'b0;
            if (w_wr_fire) begin
                SRAM_CEn   <= 1'b0;
                SRAM_WEn   <= 1'b0;
                SRAM_WBEn  <= w_wbe_write;
                SRAM_ADDR  <= {20'd0, r_region, r_word, 3'b000};
                SRAM_WDATA <= WR_DATA;
            end else if (w_issue) begin
                SRAM_CEn    <= 1'b0;
                SRAM_ADDR   <= {20'd0, w_rd_loc, 3'b000};
                r_rd_strobe <= 1'b1;
            end
        end
    end

    // Read return tracking and FIFO pointers
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_rd_ret <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ret <= r_rd_strobe;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage captures the word returned the cycle after each read strobe
    always_ff @(posedge CLK) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= SRAM_RDATA;
    end

endmodule
